// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and sizing helpers for the sequential ripple adder.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_DEFAULT_WIDTH          = 8;
    localparam int c_DEFAULT_BITS_PER_CYCLE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    // Slice index counter width; a single-slice adder still needs one bit.
    function automatic int cnt_width(input int width, input int bits_per_cycle);
        int n;
        n = width / bits_per_cycle;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_slice.sv
`default_nettype none
// ============================================================================
// Module   : ripple_slice
// Brief    : Combinational W-bit full-adder chain; cout is bit W of the sum.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_slice #(
    parameter int W = 1
) (
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]         = b[i] ^ c[i] ^ w_carry[i];
        assign w_carry[i+1] = (b[i] & c[i]) | (w_carry[i] & (b[i] ^ c[i]));
    end

    assign cout = w_carry[W];

endmodule
`default_nettype wire

// File: rtl/alu_ripple_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_ripple_adder_seq
// Brief    : Multi-cycle ripple-carry adder resolving BITS_PER_CYCLE bits/clock.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ripple_adder_seq
    import alu_pkg::*;
#(
    parameter int WIDTH          = c_DEFAULT_WIDTH,
    parameter int BITS_PER_CYCLE = c_DEFAULT_BITS_PER_CYCLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             zero,
    output logic             sign
);

    localparam int c_N     = WIDTH / BITS_PER_CYCLE;
    localparam int c_CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("alu_ripple_adder_seq: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end

    adder_state_t r_state;
    adder_state_t w_next_state;

    logic [c_CNT_W-1:0]        r_idx;
    logic [WIDTH-1:0]          r_b;
    logic [WIDTH-1:0]          r_c;
    logic [WIDTH-1:0]          r_work;
    logic                      r_carry;
    logic [WIDTH-1:0]          r_sum;
    logic                      r_carry_out;
    logic                      r_zero;
    logic                      r_sign;

    logic [BITS_PER_CYCLE-1:0] w_b_slice;
    logic [BITS_PER_CYCLE-1:0] w_c_slice;
    logic [BITS_PER_CYCLE-1:0] w_s_slice;
    logic                      w_cout;
    logic                      w_last;
    logic [WIDTH-1:0]          w_final;

    always_comb begin
        w_b_slice = '0;
        w_c_slice = '0;
        for (int k = 0; k < c_N; k++) begin
            if (r_idx == c_CNT_W'(k)) begin
                w_b_slice = r_b[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
                w_c_slice = r_c[k*BITS_PER_CYCLE +: BITS_PER_CYCLE];
            end
        end
    end

    ripple_slice #(
        .W (BITS_PER_CYCLE)
    ) u_slice (
        .b    (w_b_slice),
        .c    (w_c_slice),
        .cin  (r_carry),
        .s    (w_s_slice),
        .cout (w_cout)
    );

    assign w_last = (r_idx == c_CNT_W'(c_N - 1));

    // The last slice is always the top one, so splice it onto the working sum.
    always_comb begin
        w_final = r_work;
        w_final[WIDTH-1 -: BITS_PER_CYCLE] = w_s_slice;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Results are loaded on the edge into DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_work      <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
            r_sign      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_b     <= b;
                        r_c     <= c;
                        r_carry <= carry_in;
                        r_idx   <= '0;
                        r_work  <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < c_N; k++) begin
                        if (r_idx == c_CNT_W'(k)) begin
                            r_work[k*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= w_s_slice;
                        end
                    end
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum       <= w_final;
                        r_carry_out <= w_cout;
                        r_zero      <= (w_final == '0);
                        r_sign      <= w_final[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign carry = r_carry_out;
    assign zero  = r_zero;
    assign sign  = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_alu_ripple_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ripple_adder_seq
// Brief    : Randomized self-checking bench for 8/1 and 16/4 adder configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ripple_adder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        rst8, start8, ci8;
    logic [7:0]  b8, c8;
    logic        busy8, done8, carry8, zero8, sign8;
    logic [7:0]  sum8;

    logic        rst16, start16, ci16;
    logic [15:0] b16, c16;
    logic        busy16, done16, carry16, zero16, sign16;
    logic [15:0] sum16;

    alu_ripple_adder_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .b(b8), .c(c8), .carry_in(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .zero(zero8), .sign(sign8)
    );

    alu_ripple_adder_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .reset(rst16), .start(start16), .b(b16), .c(c16), .carry_in(ci16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .zero(zero16), .sign(sign16)
    );

    // Reference model: plain integer addition, carry is the bit above the word.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        return 9'(x) + 9'(y) + 9'(ci);
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        return 17'(x) + 17'(y) + 17'(ci);
    endfunction

    // Drives one add on dut8 and waits (bounded) for done; observes latency/busy/hold.
    task automatic add8(input logic [7:0] bb, input logic [7:0] cc, input logic ci,
                        output logic [7:0] s, output logic co, output logic z, output logic sg,
                        output int lat, output int nbusy, output bit early);
        logic [10:0] prev;
        @(negedge clk);
        prev = {sum8, carry8, zero8, sign8};
        b8 = bb; c8 = cc; ci8 = ci; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; b8 = 8'($urandom); c8 = 8'($urandom); ci8 = 1'($urandom);
        lat = 1; nbusy = 0; early = 1'b0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) nbusy++;
            if ({sum8, carry8, zero8, sign8} !== prev) early = 1'b1;
            @(negedge clk);
            lat++;
        end
        s = sum8; co = carry8; z = zero8; sg = sign8;
    endtask

    task automatic add16(input logic [15:0] bb, input logic [15:0] cc, input logic ci,
                         output logic [15:0] s, output logic co, output logic z, output logic sg,
                         output int lat);
        @(negedge clk);
        b16 = bb; c16 = cc; ci16 = ci; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; b16 = 16'($urandom); c16 = 16'($urandom);
        lat = 1;
        while (done16 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s = sum16; co = carry16; z = zero16; sg = sign16;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst16 = 1'b1; start8 = 1'b1; start16 = 1'b1;
        b8 = 8'h12; c8 = 8'h34; ci8 = 1'b1; b16 = 16'h1234; c16 = 16'h5678; ci16 = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy8, done8, sum8, carry8, zero8, sign8} !== 13'd0) begin
            n_err++;
            $display("FAIL reset8 outputs got %b want all zero", {busy8, done8, sum8, carry8, zero8, sign8});
        end
        n_vec++;
        if ({busy16, done16, sum16, carry16, zero16, sign16} !== 21'd0) begin
            n_err++;
            $display("FAIL reset16 outputs got %b want all zero", {busy16, done16, sum16, carry16, zero16, sign16});
        end
        start8 = 1'b0; start16 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy8 !== 1'b0 || busy16 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_priority busy got %b%b want 00", busy8, busy16);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  tb_b [3] = '{8'h35, 8'hFF, 8'h7F};
        logic [7:0]  tb_c [3] = '{8'h4A, 8'h01, 8'h00};
        logic        tb_ci[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0]  s;
        logic        co, z, sg;
        logic [8:0]  exp;
        int          lat, nb;
        bit          early;
        for (int i = 0; i < 3; i++) begin
            add8(tb_b[i], tb_c[i], tb_ci[i], s, co, z, sg, lat, nb, early);
            exp = ref8(tb_b[i], tb_c[i], tb_ci[i]);
            n_vec++;
            if ({co, s, z, sg} !== {exp, exp[7:0] == 8'd0, exp[7]}) begin
                n_err++;
                $display("FAIL directed%0d result got c=%b s=%h z=%b sg=%b want c=%b s=%h z=%b sg=%b",
                         i, co, s, z, sg, exp[8], exp[7:0], exp[7:0] == 8'd0, exp[7]);
            end
            n_vec++;
            if (lat !== 9 || nb !== 8) begin
                n_err++;
                $display("FAIL directed%0d timing got lat=%0d busy=%0d want lat=9 busy=8", i, lat, nb);
            end
            n_vec++;
            if (early || busy8 !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d hold got early=%0d busy=%b want early=0 busy=0", i, early, busy8);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        @(negedge clk);
        b8 = 8'h35; c8 = 8'h4A; ci8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        b8 = 8'h01; c8 = 8'h01;
        for (int cyc = 1; cyc < 24; cyc++) begin
            if (cyc == 10) start8 = 1'b0;
            if (done8 === 1'b1) dones++;
            @(negedge clk);
        end
        n_vec++;
        if (dones !== 1 || sum8 !== 8'h7F || busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start got dones=%0d sum=%h busy=%b want dones=1 sum=7f busy=0",
                     dones, sum8, busy8);
        end
    endtask

    task automatic test_midrun_reset();
        int dones = 0;
        logic [7:0] s;
        logic co, z, sg;
        int lat, nb;
        bit early;
        @(negedge clk);
        b8 = 8'hC3; c8 = 8'h5A; ci8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        n_vec++;
        if ({busy8, done8, sum8, carry8, zero8, sign8} !== 13'd0) begin
            n_err++;
            $display("FAIL midrun_reset outputs got %b want all zero", {busy8, done8, sum8, carry8, zero8, sign8});
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done8 === 1'b1 || busy8 === 1'b1) dones++;
            @(negedge clk);
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL midrun_reset activity got %0d busy/done cycles want 0", dones);
        end
        add8(8'h80, 8'h80, 1'b1, s, co, z, sg, lat, nb, early);
        n_vec++;
        if ({co, s, z, sg} !== {1'b1, 8'h01, 1'b0, 1'b0} || lat !== 9) begin
            n_err++;
            $display("FAIL after_reset got c=%b s=%h z=%b sg=%b lat=%0d want c=1 s=01 z=0 sg=0 lat=9",
                     co, s, z, sg, lat);
        end
    endtask

    task automatic test_random8();
        logic [7:0] bb, cc, s;
        logic       ci, co, z, sg;
        logic [8:0] exp;
        int         lat, nb;
        bit         early;
        for (int i = 0; i < 25; i++) begin
            bb = 8'($urandom); cc = 8'($urandom); ci = 1'($urandom);
            if (i == 0) begin bb = 8'h00; cc = 8'h00; ci = 1'b0; end
            add8(bb, cc, ci, s, co, z, sg, lat, nb, early);
            exp = ref8(bb, cc, ci);
            n_vec++;
            if ({co, s, z, sg} !== {exp, exp[7:0] == 8'd0, exp[7]} || lat !== 9 || nb !== 8 || early) begin
                n_err++;
                $display("FAIL rand8 b=%h c=%h ci=%b got c=%b s=%h z=%b sg=%b lat=%0d want c=%b s=%h z=%b sg=%b lat=9",
                         bb, cc, ci, co, s, z, sg, lat, exp[8], exp[7:0], exp[7:0] == 8'd0, exp[7]);
            end
        end
    endtask

    task automatic test_wide();
        logic [15:0] bb, cc, s;
        logic        ci, co, z, sg;
        logic [16:0] exp;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            bb = 16'($urandom); cc = 16'($urandom); ci = 1'($urandom);
            if (i == 0) begin bb = 16'hFFFF; cc = 16'h0001; ci = 1'b0; end
            add16(bb, cc, ci, s, co, z, sg, lat);
            exp = ref16(bb, cc, ci);
            n_vec++;
            if ({co, s, z, sg} !== {exp, exp[15:0] == 16'd0, exp[15]} || lat !== 5) begin
                n_err++;
                $display("FAIL wide16 b=%h c=%h ci=%b got c=%b s=%h z=%b sg=%b lat=%0d want c=%b s=%h z=%b sg=%b lat=5",
                         bb, cc, ci, co, s, z, sg, lat, exp[16], exp[15:0], exp[15:0] == 16'd0, exp[15]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        int bad = 0;
        @(negedge clk);
        b16 = 16'hFFFF; c16 = 16'h0001; ci16 = 1'b0; start16 = 1'b1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                done_cyc.push_back(cyc);
                if ({carry16, sum16, zero16} !== {1'b1, 16'h0000, 1'b1}) bad++;
            end
        end
        start16 = 1'b0;
        repeat (8) @(negedge clk);
        n_vec++;
        if (done_cyc.size() != 6 || done_cyc[0] != 5 || bad != 0) begin
            n_err++;
            $display("FAIL back_to_back got %0d dones first=%0d badres=%0d want 6 dones first=5 badres=0",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, bad);
        end
        for (int i = 1; i < done_cyc.size(); i++) begin
            n_vec++;
            if (done_cyc[i] - done_cyc[i-1] != 6) begin
                n_err++;
                $display("FAIL back_to_back spacing%0d got %0d want 6", i, done_cyc[i] - done_cyc[i-1]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_midrun_reset();
        test_random8();
        test_wide();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
